// File: rtl/ahb_apb_bridge.sv
// Single-clock AHB-Lite slave to APB master bridge.
// One transfer in flight; size errors and APB errors or timeouts return a two-cycle AHB ERROR response.
module ahb_apb_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_hselx,
    input  logic                  i_hready,
    input  logic                  i_htrans,
    input  logic [2:0]            i_hsize,
    input  logic                  i_hwrite,
    input  logic [ADDR_WIDTH-1:0] i_haddr,
    input  logic [DATA_WIDTH-1:0] i_hwdata,
    output logic                  o_hreadyout,
    output logic                  o_hresp,
    output logic [DATA_WIDTH-1:0] o_hrdata,
    output logic                  o_psel,
    output logic                  o_penable,
    output logic                  o_pwrite,
    output logic [ADDR_WIDTH-1:0] o_paddr,
    output logic [DATA_WIDTH-1:0] o_pwdata,
    input  logic [DATA_WIDTH-1:0] i_prdata,
    input  logic                  i_pready,
    input  logic                  i_pslverr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WDATA,
        S_SETUP,
        S_ACCESS,
        S_ERR1,
        S_ERR2
    } state_e;

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_e                  state_q, state_d;
    logic                    hreadyout_q, hreadyout_d;
    logic                    hresp_q, hresp_d;
    logic [DATA_WIDTH-1:0]   hrdata_q, hrdata_d;
    logic                    pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    valid;

    assign valid = i_hselx & i_htrans & i_hready;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves a latch behind.
        state_d     = state_q;
        hreadyout_d = hreadyout_q;
        hresp_d     = hresp_q;
        hrdata_d    = hrdata_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        cnt_d       = '0;

        unique case (state_q)
            S_IDLE: begin
                hreadyout_d = 1'b1;
                hresp_d     = 1'b0;
                if (valid) begin
                    paddr_d     = i_haddr;
                    pwrite_d    = i_hwrite;
                    hreadyout_d = 1'b0;
                    if (i_hsize > 3'b010) begin
                        state_d = S_ERR1;
                        hresp_d = 1'b1;
                    end else if (i_hwrite) begin
                        state_d = S_WDATA;
                    end else begin
                        state_d = S_SETUP;
                    end
                end
            end
            S_WDATA: begin
                pwdata_d = i_hwdata;
                state_d  = S_SETUP;
            end
            S_SETUP: begin
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (i_pready) begin
                    if (i_pslverr) begin
                        state_d = S_ERR1;
                        hresp_d = 1'b1;
                    end else begin
                        state_d     = S_IDLE;
                        hreadyout_d = 1'b1;
                        if (!pwrite_q) hrdata_d = i_prdata;
                    end
                end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
                    state_d = S_ERR1;
                    hresp_d = 1'b1;
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ERR1: begin
                state_d     = S_ERR2;
                hresp_d     = 1'b1;
                hreadyout_d = 1'b1;
            end
            S_ERR2: begin
                state_d     = S_IDLE;
                hresp_d     = 1'b0;
                hreadyout_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            hrdata_q    <= '0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            hrdata_q    <= hrdata_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            cnt_q       <= cnt_d;
        end
    end

    assign o_hreadyout = hreadyout_q;
    assign o_hresp     = hresp_q;
    assign o_hrdata    = hrdata_q;
    assign o_psel      = (state_q == S_SETUP) || (state_q == S_ACCESS);
    assign o_penable   = (state_q == S_ACCESS);
    assign o_pwrite    = pwrite_q;
    assign o_paddr     = paddr_q;
    assign o_pwdata    = pwdata_q;

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Directed bench for ahb_apb_bridge: one instance with the default timeout, one with the timeout disabled.
// Both share stimulus; the second is only examined during the stuck-APB scenario.
module tb_ahb_apb_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hselx = 1'b0, hready = 1'b1, htrans = 1'b0, hwrite = 1'b0;
    logic [2:0]  hsize = 3'b010;
    logic [31:0] haddr = '0, hwdata = '0, prdata = '0;
    logic        pready = 1'b0, pslverr = 1'b0;

    logic        hreadyout, hresp, psel, penable, pwrite;
    logic [31:0] hrdata, paddr, pwdata;
    logic        nt_hreadyout, nt_hresp, nt_psel, nt_penable, nt_pwrite;
    logic [31:0] nt_hrdata, nt_paddr, nt_pwdata;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ahb_apb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_hselx(hselx), .i_hready(hready), .i_htrans(htrans),
        .i_hsize(hsize), .i_hwrite(hwrite), .i_haddr(haddr), .i_hwdata(hwdata),
        .o_hreadyout(hreadyout), .o_hresp(hresp), .o_hrdata(hrdata),
        .o_psel(psel), .o_penable(penable), .o_pwrite(pwrite), .o_paddr(paddr), .o_pwdata(pwdata),
        .i_prdata(prdata), .i_pready(pready), .i_pslverr(pslverr)
    );

    ahb_apb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(0)) dut_nt (
        .i_clk(clk), .i_rst(rst), .i_hselx(hselx), .i_hready(hready), .i_htrans(htrans),
        .i_hsize(hsize), .i_hwrite(hwrite), .i_haddr(haddr), .i_hwdata(hwdata),
        .o_hreadyout(nt_hreadyout), .o_hresp(nt_hresp), .o_hrdata(nt_hrdata),
        .o_psel(nt_psel), .o_penable(nt_penable), .o_pwrite(nt_pwrite), .o_paddr(nt_paddr),
        .o_pwdata(nt_pwdata),
        .i_prdata(prdata), .i_pready(pready), .i_pslverr(pslverr)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Outputs are sampled 1ns after the rising edge; inputs change at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic addr_phase(input logic wr, input logic [31:0] a, input logic [2:0] sz);
        hselx  = 1'b1;
        htrans = 1'b1;
        hready = 1'b1;
        hwrite = wr;
        haddr  = a;
        hsize  = sz;
    endtask

    task automatic bus_idle();
        hselx  = 1'b0;
        htrans = 1'b0;
        hwrite = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int low_cycles;
        int psel_cycles;
        int acc_cycles;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        check("rst_hreadyout", hreadyout, 1);
        check("rst_hresp", hresp, 0);
        check("rst_hrdata", hrdata, 0);
        check("rst_psel_penable", {psel, penable}, 0);
        check("rst_pwrite", pwrite, 0);
        check("rst_paddr", paddr, 0);
        check("rst_pwdata", pwdata, 0);

        // Zero-wait read: SETUP then ACCESS then done
        pready = 1'b1;
        prdata = 32'hCAFEF00D;
        addr_phase(1'b0, 32'h4000_0010, 3'b010);
        tick();
        bus_idle();
        check("rd_setup_psel_penable", {psel, penable}, 2'b10);
        check("rd_setup_paddr", paddr, 32'h4000_0010);
        check("rd_setup_pwrite", pwrite, 0);
        check("rd_setup_hreadyout", hreadyout, 0);
        tick();
        check("rd_access_psel_penable", {psel, penable}, 2'b11);
        check("rd_access_hreadyout", hreadyout, 0);
        tick();
        check("rd_done_psel", psel, 0);
        check("rd_done_hreadyout_hresp", {hreadyout, hresp}, 2'b10);
        check("rd_done_hrdata", hrdata, 32'hCAFEF00D);

        // Write with three APB wait states: WDATA + SETUP + 4 ACCESS cycles = 6 low cycles
        pready = 1'b0;
        addr_phase(1'b1, 32'h4000_0004, 3'b010);
        tick();
        bus_idle();
        hwdata = 32'h1234_5678;
        check("wr_wdata_psel", psel, 0);
        low_cycles  = 0;
        psel_cycles = 0;
        acc_cycles  = 0;
        for (int i = 0; i < 20; i++) begin
            if (hreadyout) break;
            low_cycles++;
            if (psel) begin
                psel_cycles++;
                check("wr_pwdata_stable", pwdata, 32'h1234_5678);
                check("wr_paddr_stable", paddr, 32'h4000_0004);
            end
            if (penable) acc_cycles++;
            pready = (acc_cycles == 4);
            tick();
            hwdata = 32'hFFFF_FFFF;
        end
        check("wr_hreadyout_low_cycles", low_cycles, 6);
        check("wr_psel_cycles", psel_cycles, 5);
        check("wr_done_hresp_psel", {hresp, psel}, 2'b00);
        check("wr_hrdata_untouched", hrdata, 32'hCAFEF00D);

        // Read ending in PSLVERR: two-cycle ERROR, hrdata kept, no new transfer taken in ERR1/ERR2
        pready  = 1'b1;
        pslverr = 1'b1;
        prdata  = 32'hDEAD_BEEF;
        addr_phase(1'b0, 32'h4000_0020, 3'b010);
        tick();
        bus_idle();
        tick();
        check("err_access_penable", penable, 1);
        tick();
        pslverr = 1'b0;
        addr_phase(1'b0, 32'h4000_0024, 3'b010);
        check("err1_hresp_hreadyout", {hresp, hreadyout}, 2'b10);
        check("err1_psel", psel, 0);
        check("err1_hrdata_kept", hrdata, 32'hCAFEF00D);
        tick();
        check("err2_hresp_hreadyout", {hresp, hreadyout}, 2'b11);
        check("err2_psel", psel, 0);
        tick();
        bus_idle();
        check("err_idle_hresp_hreadyout", {hresp, hreadyout}, 2'b01);
        check("err_idle_psel", psel, 0);
        tick();
        check("err_no_late_accept", {psel, hreadyout}, 2'b01);

        // Oversized transfer: ERROR response without any APB select
        addr_phase(1'b0, 32'h4000_0040, 3'b011);
        tick();
        bus_idle();
        hsize = 3'b010;
        check("size_err1", {hresp, hreadyout, psel}, 3'b100);
        tick();
        check("size_err2", {hresp, hreadyout, psel}, 3'b110);
        tick();
        check("size_idle", {hresp, hreadyout, psel}, 3'b010);

        // Non-selected / idle / not-ready address phases are ignored
        addr_phase(1'b0, 32'h4000_0050, 3'b010);
        hselx = 1'b0;
        tick();
        check("ignore_hselx0", {psel, hreadyout}, 2'b01);
        hselx  = 1'b1;
        htrans = 1'b0;
        tick();
        check("ignore_htrans0", {psel, hreadyout}, 2'b01);
        htrans = 1'b1;
        hready = 1'b0;
        tick();
        check("ignore_hready0", {psel, hreadyout}, 2'b01);
        hready = 1'b1;
        bus_idle();

        // Back-to-back reads: second address phase in the cycle hreadyout returns high
        prdata = 32'h1111_2222;
        addr_phase(1'b0, 32'h4000_0060, 3'b010);
        tick();
        bus_idle();
        tick();
        tick();
        check("b2b_first_hrdata", hrdata, 32'h1111_2222);
        check("b2b_first_hreadyout", hreadyout, 1);
        prdata = 32'h3333_4444;
        addr_phase(1'b0, 32'h4000_0064, 3'b010);
        tick();
        bus_idle();
        check("b2b_second_setup", {psel, penable, hreadyout}, 3'b100);
        check("b2b_second_paddr", paddr, 32'h4000_0064);
        tick();
        tick();
        check("b2b_second_hrdata", hrdata, 32'h3333_4444);
        check("b2b_second_done", {hreadyout, hresp}, 2'b10);

        // Stuck APB slave: TIMEOUT=16 gives 16 ACCESS cycles then ERROR; TIMEOUT=0 keeps waiting
        pready = 1'b0;
        prdata = 32'h7777_8888;
        addr_phase(1'b0, 32'h4000_0070, 3'b010);
        tick();
        bus_idle();
        acc_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            if (penable) acc_cycles++;
            else if (acc_cycles > 0) break;
            tick();
        end
        check("to_access_cycles", acc_cycles, 16);
        check("to_err1", {hresp, hreadyout, psel, penable}, 4'b1000);
        check("to_hrdata_kept", hrdata, 32'h3333_4444);
        check("nt_still_access", {nt_psel, nt_penable, nt_hreadyout}, 3'b110);
        tick();
        check("to_err2", {hresp, hreadyout}, 2'b11);
        tick();
        check("to_idle", {hresp, hreadyout}, 2'b01);
        for (int i = 0; i < 20; i++) tick();
        check("nt_still_waiting", {nt_psel, nt_penable, nt_hreadyout, nt_hresp}, 4'b1100);
        pready = 1'b1;
        tick();
        check("nt_done", {nt_psel, nt_hreadyout, nt_hresp}, 3'b010);
        check("nt_hrdata", nt_hrdata, 32'h7777_8888);

        // Reset during ACCESS, then a clean read
        pready = 1'b0;
        addr_phase(1'b1, 32'h4000_0008, 3'b010);
        tick();
        bus_idle();
        hwdata = 32'hA5A5_A5A5;
        tick();
        tick();
        check("mid_rst_in_access", penable, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_psel_penable", {psel, penable}, 2'b00);
        check("mid_rst_hreadyout_hresp", {hreadyout, hresp}, 2'b10);
        check("mid_rst_paddr_pwdata", {paddr, pwdata}, 64'h0);
        check("mid_rst_pwrite_hrdata", {pwrite, hrdata}, 33'h0);
        pready = 1'b1;
        prdata = 32'h5555_AAAA;
        addr_phase(1'b0, 32'h4000_0030, 3'b010);
        tick();
        bus_idle();
        check("post_rst_setup", {psel, penable}, 2'b10);
        tick();
        tick();
        check("post_rst_hrdata", hrdata, 32'h5555_AAAA);
        check("post_rst_done", {hreadyout, hresp, psel}, 3'b100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
